// File: rtl/ch2_tick_pkg.sv
// Shared types and constants for the tap tick counter.
// The optional CH2_TAP_BOTH_EDGE_EN build is handled in ch2_sync_edge.
package ch2_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_Q0 = 2'd0;
  localparam logic [1:0] SEL_Q1 = 2'd1;
  localparam logic [1:0] SEL_Q2 = 2'd2;
  localparam logic [1:0] SEL_Q3 = 2'd3;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Wide enough to hold SYNC_STAGES+1 for the largest legal SYNC_STAGES (4).
  localparam int BLANK_W = 3;

endpackage

// File: rtl/ch2_sync_edge.sv
// Tap synchroniser, history flop and edge detector with blanking.
// Define CH2_TAP_BOTH_EDGE_EN to report falling as well as rising edges.
module ch2_sync_edge
  import ch2_tick_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  input  logic blank_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   sync_last;
  logic                   raw_edge;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // History keeps following the synchroniser even while blanked, so a mux
  // switch can never leave a stale level behind to fake an edge later.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    hist_d = sync_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  always_comb begin
`ifdef CH2_TAP_BOTH_EDGE_EN
    raw_edge = sync_last ^ hist_q;
`else
    raw_edge = sync_last & ~hist_q;
`endif
    edge_o = raw_edge & ~blank_i;
  end

endmodule

// File: rtl/ch2_tap_tick_counter.sv
// Selects a ripple-divider tap, turns its edges into CLK-domain ticks and
// counts them inside a START/STOP window (see CH2_TAP_BOTH_EDGE_EN option).
module ch2_tap_tick_counter
  import ch2_tick_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       Q_IN,
  input  logic [1:0]       SEL,
  input  logic             START,
  input  logic             STOP,
  input  logic             CLR,
  output logic             TICK,
  output logic [WIDTH-1:0] CNT,
  output logic             RUNNING,
  output logic             DONE,
  output logic             OVF
);

  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(SYNC_STAGES + 1);

  logic [1:0]         sel_q, sel_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               blank;
  logic               tap;
  logic               tick_d, tick_q;
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   cnt_inc;
  logic               wrap;

  // A select change restarts the blanking window that covers the
  // synchroniser refill plus the history flop catching up.
  always_comb begin
    sel_d   = sel_q;
    blank_d = blank_q;
    if (SEL != sel_q) begin
      sel_d   = SEL;
      blank_d = BLANK_LOAD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BLANK_W'(1);
    end
  end

  assign blank = (blank_q != '0);

  always_comb begin
    tap = Q_IN[0];
    case (sel_q)
      SEL_Q0: tap = Q_IN[0];
      SEL_Q1: tap = Q_IN[1];
      SEL_Q2: tap = Q_IN[2];
      SEL_Q3: tap = Q_IN[3];
      default: tap = Q_IN[0];
    endcase
  end

  ch2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (CLK),
    .rst_n   (RST_N),
    .async_i (tap),
    .blank_i (blank),
    .edge_o  (tick_d)
  );

  assign cnt_inc = cnt_q + WIDTH'(1);
  assign wrap    = (cnt_q == '1);

  // CLR beats STOP beats START; a tick arriving with STOP still counts,
  // a tick arriving with START is discarded by the restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (CLR) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (STOP) begin
            state_d = ST_DONE;
            if (tick_d) begin
              cnt_d = cnt_inc;
              ovf_d = ovf_q | wrap;
            end
          end else if (START) begin
            cnt_d = '0;
            ovf_d = 1'b0;
          end else if (tick_d) begin
            cnt_d = cnt_inc;
            ovf_d = ovf_q | wrap;
          end
        end
        ST_DONE: begin
          if (START && !STOP) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q     <= SEL_Q0;
      blank_q   <= '0;
      tick_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign TICK    = tick_q;
  assign CNT     = cnt_q;
  assign RUNNING = running_q;
  assign DONE    = done_q;
  assign OVF     = ovf_q;

endmodule
